// File: rtl/edge_sync_detect.sv
// rtl/edge_sync_detect.sv - multi-channel synchronised, glitch-filtered edge detector with sticky status
// Optional per-channel event counters are built when EDGE_CNT_EN is defined.
module edge_sync_detect #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 0,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic [WIDTH-1:0]       in,
    input  logic [2*WIDTH-1:0]     mode,
    input  logic [WIDTH-1:0]       clr,
    output logic [WIDTH-1:0]       pulse,
    output logic [WIDTH-1:0]       level,
    output logic [WIDTH-1:0]       status,
    output logic                   irq,
    output logic [WIDTH*CNT_W-1:0] cnt
);

    localparam int FW = (FILT_LEN == 0) ? 1 : $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [FW-1:0]          stab_q;
        logic                   level_q;
        logic                   pulse_q;
        logic                   status_q;
        logic                   sync_out;
        logic                   accept;
        logic                   dir_en;

        assign sync_out = sync_q[SYNC_STAGES-1];
        assign accept   = (sync_out != level_q) && (stab_q == FILT_MAX);
        // mode bit 0 enables rising, bit 1 falling; the new level tells the direction
        assign dir_en   = sync_out ? mode[2*i] : mode[2*i+1];

        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                sync_q   <= '0;
                stab_q   <= '0;
                level_q  <= 1'b0;
                pulse_q  <= 1'b0;
                status_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], in[i]};
                if (sync_out == level_q) begin
                    stab_q <= '0;
                end else if (stab_q == FILT_MAX) begin
                    level_q <= sync_out;
                    stab_q  <= '0;
                end else begin
                    stab_q <= stab_q + 1'b1;
                end
                pulse_q  <= accept & dir_en;
                // set wins over a simultaneous clear
                status_q <= pulse_q | (status_q & ~clr[i]);
            end
        end

        assign level[i]  = level_q;
        assign pulse[i]  = pulse_q;
        assign status[i] = status_q;

`ifdef EDGE_CNT_EN
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                cnt_q <= '0;
            end else if (clr[i]) begin
                cnt_q <= pulse_q ? CNT_W'(1) : '0;
            end else if (pulse_q && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign cnt[i*CNT_W +: CNT_W] = cnt_q;
`else
        assign cnt[i*CNT_W +: CNT_W] = '0;
`endif
    end

    assign irq = |status;

endmodule

// File: doc/edge_sync_detect.md
# edge_sync_detect

Parametrised multi-channel edge detector for asynchronous level inputs (GPIO, external strobes, cross-domain flags). Each channel is synchronised, glitch-filtered, and edge-detected in a per-channel selectable mode. It then produces a one-cycle pulse, a sticky status bit with write-1-to-clear, and optional per-channel event counters. It is the generalised successor of the fixed 8-bit rising-edge synchroniser and feeds interrupt and event logic in the `clk` domain.

## Interface
- WIDTH, 8, number of independent channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per channel (2..4)
- FILT_LEN, 0, extra consecutive cycles a new level must hold before acceptance (0 = no filtering)
- CNT_W, 8, event counter width per channel
- clk  input  1  single clock; all logic on rising edge
- arstn  input  1  asynchronous active-low reset
- in  input  WIDTH  asynchronous level inputs
- mode  input  2*WIDTH  per channel: 00 off, 01 rising, 10 falling, 11 both
- clr  input  WIDTH  per-channel write-1-to-clear for status and counter
- pulse  output  WIDTH  one-cycle detected-edge pulse, registered
- level  output  WIDTH  filtered, synchronised level
- status  output  WIDTH  sticky edge-seen flags
- irq  output  1  OR of all status bits
- cnt  output  WIDTH*CNT_W  per-channel event counters, channel i at [i*CNT_W +: CNT_W]

## Operation
- Per channel: SYNC_STAGES-flop synchroniser, then filter register `level` with a stability counter of width clog2(FILT_LEN+1), minimum 1.
- Each edge: if sync_out == level, the stability counter is cleared. If they differ and the counter == FILT_LEN, `level` takes sync_out and the counter clears. Otherwise the counter increments.
- A level change is accepted only after FILT_LEN+1 consecutive differing samples. Any sample back at the old level restarts the count, so glitches shorter than FILT_LEN+1 cycles are dropped.
- On the edge where `level` changes, pulse[i] is set if mode[i] enables that direction; otherwise it is 0. Mode is sampled on that same edge only. A mode change never produces a retroactive pulse.
- Mode 00 still tracks `level` but never pulses.
- status[i]: set by pulse[i] and cleared by clr[i]. When both occur on the same edge, set wins.
- irq = |status, combinational from the status flops.

## Timing
- Reset: all synchroniser flops, level, stability counters, pulse, status, and cnt are 0. irq is 0.
- A channel held high across reset release is treated as a 0→1 transition: it yields a rising pulse if enabled.
- Latency: for a new value captured at sampling edge E0, level and pulse update at edge E(SYNC_STAGES+FILT_LEN). Pulse is high for exactly one cycle after that edge. Status follows on the next edge.
- Back-to-back edges are handled: consecutive toggles spaced at least FILT_LEN+1 cycles apart each produce a pulse, with no minimum gap beyond that.
- Reset asserted mid-filtering discards the pending transition. Channels are fully independent.

## Configuration
- EDGE_CNT_EN defined: each channel has a CNT_W-bit counter.
  - The counter increments on pulse[i] and saturates at all-ones.
  - clr[i] clears it.
  - If clr[i] and pulse[i] occur on the same edge, the counter becomes 1.
- EDGE_CNT_EN undefined: no counter logic is built and cnt is constant 0. The port list is unchanged.

## Test plan
- Settings WIDTH=8, SYNC_STAGES=2, FILT_LEN=0, all modes 01. Drive in 0x00→0x02 sampled at E0 → pulse=0x02 for one cycle after E2, status=0x02 from E3, irq=1.
- in 0x02→0x0E, then 0x00 twenty cycles later, with modes 11 on channels 1–3 → pulse=0x0C on the rise, pulse=0x0E on the fall, one cycle each.
- Set FILT_LEN=2. A 2-cycle high glitch on in[0] → no pulse and level[0] stays 0. A 3-cycle high on in[0] → pulse[0] at E4, level[0]=1.
- Pulse on ch0 and clr=0x01 on the same edge → status[0]=1. A later clr=0x01 alone → status[0]=0, irq=0.
- With EDGE_CNT_EN and CNT_W=2, apply 5 rising edges on ch5 → cnt ch5 saturates at 3. clr on ch5 → 0.
- Hold in=0xFF through reset release with modes 01 → pulse=0xFF once, after E2 post-release. Drop arstn mid-filter → all outputs return to 0 immediately.
